// File: rtl/fp_div_param.sv
// fp_div_param: multi-cycle IEEE-754-style divider, z = a / b.
// Restoring division at one quotient bit per cycle. Handles NaN, inf, zero and
// subnormal operands, and rounds to nearest even.
// The default parameters give half precision. One operation is in flight at a time.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_a, in_b            dividend / divisor (W = 1+EXP_W+MAN_W bits)
//   in_valid, in_ready    operand handshake
//   out_z                 quotient, held while out_valid && !out_ready
//   out_valid, out_ready  result handshake
//   out_flags             {invalid, div_zero, overflow, underflow, inexact};
//                         present only when FP_DIV_FLAGS_EN is defined
//
// state     | meaning
// IDLE      | waiting for an operand transfer
// UNPACK    | split sign / unbiased exponent / mantissa
// SPECIAL   | resolve NaN, inf and zero cases; otherwise go on to normalise
// NORM_A    | left-normalise the dividend mantissa
// NORM_B    | left-normalise the divisor mantissa, then seed the divider
// DIV       | one restoring-division quotient bit per cycle
// NORM      | normalise the quotient, then denormalise into the subnormal range
// ROUND     | round to nearest even, renormalise on carry-out
// PACK      | build the result word (overflow -> inf)
// OUT       | present the result until out_ready
module fp_div_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] out_z,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]           out_flags
`endif
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int SW   = MAN_W + 4;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int CW   = $clog2(SW);
  localparam logic signed [EW-1:0] E_MIN = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_MAX = EW'(BIAS);
  localparam logic [EXP_W-1:0] F_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, F_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B,
    S_DIV, S_NORM, S_ROUND, S_PACK, S_OUT
  } state_t;

  state_t state;
  logic [W-1:0] op_a, op_b;
  logic z_s;
  logic signed [EW-1:0] a_e, b_e, z_e;
  logic [MAN_W:0] a_m, b_m, z_m;
  logic [MAN_W+1:0] rem;
  logic [SW-1:0] quo;
  logic stk;
  logic [CW-1:0] cnt;
`ifdef FP_DIV_FLAGS_EN
  logic rnd_x;
  logic [4:0] sp_f;
`endif

  logic [EXP_W-1:0] a_fld, b_fld;
  logic [MAN_W-1:0] a_frc, b_frc;
  logic a_nan, b_nan, a_inf, b_inf, a_zro, b_zro;
  assign a_fld = op_a[W-2:MAN_W];
  assign b_fld = op_b[W-2:MAN_W];
  assign a_frc = op_a[MAN_W-1:0];
  assign b_frc = op_b[MAN_W-1:0];
  assign a_nan = (&a_fld) & (|a_frc);
  assign b_nan = (&b_fld) & (|b_frc);
  assign a_inf = (&a_fld) & ~(|a_frc);
  assign b_inf = (&b_fld) & ~(|b_frc);
  assign a_zro = ~(|a_fld) & ~(|a_frc);
  assign b_zro = ~(|b_fld) & ~(|b_frc);

  logic sp_hit;
  logic [W-1:0] sp_z;
  always_comb begin
    sp_hit = 1'b1;
    sp_z   = QNAN;
`ifdef FP_DIV_FLAGS_EN
    sp_f   = 5'b00000;
`endif
    if (a_nan | b_nan) begin
      sp_z = QNAN;
    end else if ((a_inf & b_inf) | (a_zro & b_zro)) begin
`ifdef FP_DIV_FLAGS_EN
      sp_f = 5'b10000;
`endif
    end else if (a_inf) begin
      sp_z = {z_s, F_ONES, {MAN_W{1'b0}}};
    end else if (b_inf | a_zro) begin
      sp_z = {z_s, {(W-1){1'b0}}};
    end else if (b_zro) begin
      sp_z = {z_s, F_ONES, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      sp_f = 5'b01000;
`endif
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Quotient normalisation: one left shift when the integer bit is clear, then
  // a single-cycle right shift into the subnormal range with sticky collection.
  logic [SW-1:0] n_sig;
  logic signed [EW-1:0] n_e;
  logic [EW-1:0] n_d;
  logic n_stk;
  always_comb begin
    n_sig = quo[SW-1] ? quo : {quo[SW-2:0], 1'b0};
    n_e   = quo[SW-1] ? z_e : z_e - EW'(1);
    n_stk = (rem != '0);
    n_d   = '0;
    if (n_e < E_MIN) begin
      n_d = E_MIN - n_e;
      if (n_d >= EW'(SW)) begin
        n_stk = n_stk | (|n_sig);
        n_sig = '0;
      end else begin
        n_stk = n_stk | (|(n_sig & ~({SW{1'b1}} << n_d)));
        n_sig = n_sig >> n_d;
      end
      n_e = E_MIN;
    end
  end

  // quo layout after NORM: [SW-1:3] mantissa, [2] guard, [1] round, [0] folds into sticky.
  logic r_g, r_r, r_s, r_inc;
  logic [MAN_W+1:0] r_sum;
  assign r_g   = quo[2];
  assign r_r   = quo[1];
  assign r_s   = quo[0] | stk;
  assign r_inc = r_g & (r_r | r_s | quo[3]);
  assign r_sum = {1'b0, quo[SW-1:3]} + {{(MAN_W+1){1'b0}}, r_inc};

  logic [EXP_W-1:0] p_fld;
  assign p_fld = EXP_W'(z_e + E_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_z     <= '0;
`ifdef FP_DIV_FLAGS_EN
      out_flags <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            in_ready <= 1'b0;
            state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          z_s   <= op_a[W-1] ^ op_b[W-1];
          a_e   <= (a_fld == '0) ? E_MIN : EW'(a_fld) - E_MAX;
          b_e   <= (b_fld == '0) ? E_MIN : EW'(b_fld) - E_MAX;
          a_m   <= {a_fld != '0, a_frc};
          b_m   <= {b_fld != '0, b_frc};
          state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          if (sp_hit) begin
            out_z     <= sp_z;
`ifdef FP_DIV_FLAGS_EN
            out_flags <= sp_f;
`endif
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            state <= S_NORM_A;
          end
        end
        S_NORM_A: begin
          if (a_m[MAN_W]) begin
            state <= S_NORM_B;
          end else begin
            a_m <= a_m << 1;
            a_e <= a_e - EW'(1);
          end
        end
        S_NORM_B: begin
          if (b_m[MAN_W]) begin
            rem   <= {1'b0, a_m};
            quo   <= '0;
            cnt   <= CW'(SW - 1);
            z_e   <= a_e - b_e;
            state <= S_DIV;
          end else begin
            b_m <= b_m << 1;
            b_e <= b_e - EW'(1);
          end
        end
        S_DIV: begin
          if (rem >= {1'b0, b_m}) begin
            quo <= {quo[SW-2:0], 1'b1};
            rem <= (rem - {1'b0, b_m}) << 1;
          end else begin
            quo <= {quo[SW-2:0], 1'b0};
            rem <= rem << 1;
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= S_NORM;
        end
        S_NORM: begin
          quo   <= n_sig;
          stk   <= n_stk;
          z_e   <= n_e;
          state <= S_ROUND;
        end
        S_ROUND: begin
          if (r_sum[MAN_W+1]) begin
            z_m <= r_sum[MAN_W+1:1];
            z_e <= z_e + EW'(1);
          end else begin
            z_m <= r_sum[MAN_W:0];
          end
`ifdef FP_DIV_FLAGS_EN
          rnd_x <= r_g | r_r | r_s;
`endif
          state <= S_PACK;
        end
        S_PACK: begin
          if (z_e > E_MAX) begin
            out_z     <= {z_s, F_ONES, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
            out_flags <= 5'b00101;
`endif
          end else begin
            out_z     <= {z_s, z_m[MAN_W] ? p_fld : {EXP_W{1'b0}}, z_m[MAN_W-1:0]};
`ifdef FP_DIV_FLAGS_EN
            out_flags <= {3'b000, ~z_m[MAN_W] & rnd_x, rnd_x};
`endif
          end
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_param.sv
// Testbench for fp_div_param: half-precision and single-precision instances,
// compared against an exact rational reference model of IEEE division.
module tb_fp_div_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [15:0] a16, b16, z16;
  logic iv16, ir16, ov16, or16;
  logic [31:0] a32, b32, z32;
  logic iv32, ir32, ov32, or32;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0] f16, f32;
`endif

  fp_div_param dut16 (
    .clk(clk), .rst(rst), .in_a(a16), .in_b(b16), .in_valid(iv16), .in_ready(ir16),
    .out_z(z16), .out_valid(ov16), .out_ready(or16)
`ifdef FP_DIV_FLAGS_EN
    , .out_flags(f16)
`endif
  );

  fp_div_param #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_a(a32), .in_b(b32), .in_valid(iv32), .in_ready(ir32),
    .out_z(z32), .out_valid(ov32), .out_ready(or32)
`ifdef FP_DIV_FLAGS_EN
    , .out_flags(f32)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Exact model: value = m * 2^e; pick the result quantum, divide with integer
  // arithmetic, round half to even on the remainder. Returns {flags, z}.
  function automatic logic [36:0] ref_div(input int ew, input int mw,
                                          input logic [31:0] a, input logic [31:0] b);
    int bias, emx, fa, fb, ea, eb, la, lb, k, eq, e, sh, fld;
    logic sz, a_nan, b_nan, a_inf, b_inf, a_zro, b_zro, nx;
    logic [127:0] fra, frb, ma, mb, num, den, q, r, one;
    logic [31:0] zz, sgn, inf, qnan;
    logic [4:0] fl;
    one  = 128'd1;
    bias = (1 << (ew - 1)) - 1;
    emx  = (1 << ew) - 1;
    sz   = a[ew+mw] ^ b[ew+mw];
    fa   = int'((a >> mw) & 32'(emx));
    fb   = int'((b >> mw) & 32'(emx));
    fra  = 128'(a) & ((one << mw) - one);
    frb  = 128'(b) & ((one << mw) - one);
    sgn  = 32'(sz) << (ew + mw);
    inf  = sgn | (32'(emx) << mw);
    qnan = (32'(emx) << mw) | (32'd1 << (mw - 1));
    a_nan = (fa == emx) && (fra != 0);
    b_nan = (fb == emx) && (frb != 0);
    a_inf = (fa == emx) && (fra == 0);
    b_inf = (fb == emx) && (frb == 0);
    a_zro = (fa == 0) && (fra == 0);
    b_zro = (fb == 0) && (frb == 0);
    fl = 5'b00000;
    if (a_nan || b_nan) zz = qnan;
    else if ((a_inf && b_inf) || (a_zro && b_zro)) begin zz = qnan; fl = 5'b10000; end
    else if (a_inf) zz = inf;
    else if (b_inf || a_zro) zz = sgn;
    else if (b_zro) begin zz = inf; fl = 5'b01000; end
    else begin
      ma = (fa == 0) ? fra : (fra | (one << mw));
      mb = (fb == 0) ? frb : (frb | (one << mw));
      ea = ((fa == 0) ? 1 : fa) - bias - mw;
      eb = ((fb == 0) ? 1 : fb) - bias - mw;
      la = 0; lb = 0;
      for (int i = 0; i < 32; i++) begin
        if (ma[i]) la = i;
        if (mb[i]) lb = i;
      end
      k = la - lb;
      if ((ma << lb) < (mb << la)) k--;
      eq = ea - eb + k;
      e  = eq - mw;
      if (e < 1 - bias - mw) e = 1 - bias - mw;
      sh = ea - eb - e;
      if (sh >= 0) begin
        num = ma << sh; den = mb;
      end else begin
        if (sh < -100) sh = -100;
        num = ma; den = mb << (-sh);
      end
      q  = num / den;
      r  = num % den;
      nx = (r != 0);
      if (((r << 1) > den) || (((r << 1) == den) && q[0])) q = q + one;
      if (q == (one << (mw + 1))) begin q = q >> 1; e++; end
      fld = (q >= (one << mw)) ? e + mw + bias : 0;
      if (fld >= emx) begin
        zz = inf; fl = 5'b00101;
      end else begin
        zz = sgn | (32'(fld) << mw) | 32'(q & ((one << mw) - one));
        fl = {3'b000, (fld == 0) && nx, nx};
      end
    end
    return {fl, zz};
  endfunction

  function automatic bit is_special(input int ew, input int mw, input logic [31:0] x);
    int f;
    logic [31:0] mag;
    f   = int'((x >> mw) & 32'((1 << ew) - 1));
    mag = x & ((32'd1 << (ew + mw)) - 32'd1);
    return (f == (1 << ew) - 1) || (mag == 32'd0);
  endfunction

  function automatic logic [31:0] rnd_op(input int ew, input int mw);
    logic [31:0] s, e, f;
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 0) e = 32'd0;
    else if (k == 1) e = 32'((1 << ew) - 1);
    else e = 32'($urandom_range(1, (1 << ew) - 2));
    f = 32'($urandom) & ((32'd1 << mw) - 32'd1);
    if ($urandom_range(0, 5) == 0) f = 32'd0;
    s = 32'($urandom_range(0, 1));
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] z, output logic [4:0] f,
                        output int lat);
    int n;
    bit stable;
    logic [31:0] z0;
    z = '0; f = '0; lat = 0;
    @(negedge clk);
    if (wide) begin a32 = a; b32 = b; iv32 = 1'b1; end
    else begin a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; end
    n = 0;
    while (!(wide ? ir32 : ir16) && n < 50) begin @(negedge clk); n++; end
    chk_val("in_ready_idle", 64'(wide ? ir32 : ir16), 64'd1);
    @(negedge clk);
    iv16 = 1'b0; iv32 = 1'b0;
    chk_val("in_ready_busy", 64'(wide ? ir32 : ir16), 64'd0);
    lat = 1;
    while (!(wide ? ov32 : ov16) && lat < 300) begin @(negedge clk); lat++; end
    chk_val("out_valid_seen", 64'(wide ? ov32 : ov16), 64'd1);
    z = wide ? z32 : {16'h0000, z16};
`ifdef FP_DIV_FLAGS_EN
    f = wide ? f32 : f16;
`endif
    z0 = z;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if ((wide ? z32 : {16'h0000, z16}) != z0) stable = 1'b0;
      if ((wide ? ir32 : ir16) || !(wide ? ov32 : ov16)) stable = 1'b0;
    end
    if (hold > 0) chk_val("hold_stable", 64'(stable), 64'd1);
    if (wide) or32 = 1'b1; else or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0; or32 = 1'b0;
    chk_val("valid_drop", 64'(wide ? ov32 : ov16), 64'd0);
    chk_val("ready_back", 64'(wide ? ir32 : ir16), 64'd1);
  endtask

  logic [15:0] dv_a [10] = '{16'h4000, 16'h3C00, 16'h7BFF, 16'h0000, 16'hC000,
                             16'h0001, 16'h0400, 16'h7E01, 16'h7C00, 16'h3C00};
  logic [15:0] dv_b [10] = '{16'h3C00, 16'h4200, 16'h0001, 16'h0000, 16'h0000,
                             16'h4000, 16'h4000, 16'h3C00, 16'hFC00, 16'h7C00};
  logic [15:0] dv_z [10] = '{16'h4000, 16'h3555, 16'h7C00, 16'h7E00, 16'hFC00,
                             16'h0000, 16'h0200, 16'h7E00, 16'h7E00, 16'h0000};
  logic [4:0]  dv_f [10] = '{5'b00000, 5'b00001, 5'b00101, 5'b10000, 5'b01000,
                             5'b00011, 5'b00000, 5'b00000, 5'b10000, 5'b00000};

  initial begin
    logic [31:0] z, a, b;
    logic [4:0] f;
    logic [36:0] m;
    int lat;
    rst = 1'b1;
    iv16 = 1'b0; iv32 = 1'b0; or16 = 1'b0; or32 = 1'b0;
    a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    repeat (3) @(negedge clk);
    chk_val("rst_in_ready", 64'(ir16), 64'd1);
    chk_val("rst_out_valid", 64'(ov16), 64'd0);
    chk_val("rst_out_z", 64'(z16), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, {16'h0000, dv_a[i]}, {16'h0000, dv_b[i]}, (i == 0) ? 10 : 0, z, f, lat);
      chk_val($sformatf("dir_z_%0d", i), 64'(z), 64'(dv_z[i]));
`ifdef FP_DIV_FLAGS_EN
      chk_val($sformatf("dir_f_%0d", i), 64'(f), 64'(dv_f[i]));
`endif
      if (is_special(5, 10, {16'h0000, dv_a[i]}) || is_special(5, 10, {16'h0000, dv_b[i]}))
        chk_val($sformatf("dir_lat_sp_%0d", i), 64'(lat), 64'd3);
      else
        chk_val($sformatf("dir_lat_ok_%0d", i), 64'(lat <= 3 * 10 + 12), 64'd1);
    end

    // reset while the divider is busy in DIV
    @(negedge clk);
    a16 = 16'h4400; b16 = 16'h4000; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_val("midrst_in_ready", 64'(ir16), 64'd1);
    chk_val("midrst_out_valid", 64'(ov16), 64'd0);
    repeat (25) @(negedge clk);
    chk_val("midrst_no_stale", 64'(ov16), 64'd0);
    run_op(1'b0, 32'h0000_4400, 32'h0000_4000, 0, z, f, lat);
    chk_val("after_rst_z", 64'(z), 64'h4000);

    for (int i = 0; i < 80; i++) begin
      a = rnd_op(5, 10);
      b = rnd_op(5, 10);
      m = ref_div(5, 10, a, b);
      run_op(1'b0, a, b, int'($urandom_range(0, 2)), z, f, lat);
      chk_val($sformatf("h_z a=%h b=%h", a[15:0], b[15:0]), 64'(z), 64'(m[31:0]));
`ifdef FP_DIV_FLAGS_EN
      chk_val($sformatf("h_f a=%h b=%h", a[15:0], b[15:0]), 64'(f), 64'(m[36:32]));
`endif
      if (is_special(5, 10, a) || is_special(5, 10, b))
        chk_val("h_lat_sp", 64'(lat), 64'd3);
      else
        chk_val("h_lat_max", 64'(lat <= 3 * 10 + 12), 64'd1);
    end

    run_op(1'b1, 32'h4040_0000, 32'h3F80_0000, 0, z, f, lat);
    chk_val("sp_3_div_1", 64'(z), 64'h4040_0000);
    for (int i = 0; i < 20; i++) begin
      a = rnd_op(8, 23);
      b = rnd_op(8, 23);
      m = ref_div(8, 23, a, b);
      run_op(1'b1, a, b, 0, z, f, lat);
      chk_val($sformatf("s_z a=%h b=%h", a, b), 64'(z), 64'(m[31:0]));
`ifdef FP_DIV_FLAGS_EN
      chk_val($sformatf("s_f a=%h b=%h", a, b), 64'(f), 64'(m[36:32]));
`endif
      if (!(is_special(8, 23, a) || is_special(8, 23, b)))
        chk_val("s_lat_max", 64'(lat <= 3 * 23 + 12), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_div_param.md
Name: fp_div_param

Overview:
- Parametrised IEEE-754-style floating-point divider computing z = a / b. Supports configurable exponent and mantissa widths, with half precision as the default.
- Uses a multi-cycle restoring division at one quotient bit per cycle, with full special-case, subnormal and round-to-nearest-even handling.
- Sits in the FPU datapath beside the other arithmetic units. It uses a valid/ready handshake on both sides so it can be chained or back-pressured by the FPU issue logic.

Parameters:
- EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 10, stored fraction width (hidden bit excluded).
- W = 1+EXP_W+MAN_W: derived localparam for the operand/result width; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_a  in  W  dividend.
- in_b  in  W  divisor.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- out_z  out  W  quotient.
- out_valid  out  1  out_z valid.
- out_ready  in  1  consumer accepts out_z.
- out_flags  out  5  {invalid, div_zero, overflow, underflow, inexact}; present only with FP_DIV_FLAGS_EN.

Behaviour:
- Reset values (rst sampled high at posedge; overrides everything, including mid-operation): state=IDLE, in_ready=1, out_valid=0, out_z=0, out_flags=0. Any in-flight operation is discarded.
- Handshake:
  - Operands are captured on a cycle where in_valid && in_ready; in_ready then drops to 0 on the next cycle.
  - in_ready returns to 1 only after the output transfer (out_valid && out_ready).
  - One operation is in flight at a time.
  - out_z and out_flags are held stable while out_valid=1 && out_ready=0.
  - out_valid deasserts the cycle after the transfer.
- States:
  - IDLE: wait for the input transfer.
  - UNPACK: split sign, exponent and fraction; unbiased exp = field - bias.
  - SPECIAL: resolve special cases (list below); a resolved case goes directly to OUT.
    - Either operand NaN -> canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0).
    - inf/inf -> qNaN, invalid.
    - 0/0 -> qNaN, invalid.
    - inf/finite -> inf, sign a_s^b_s.
    - finite/inf -> signed zero.
    - 0/nonzero -> signed zero.
    - nonzero finite/0 -> signed inf, div_zero.
    - Otherwise: set the hidden bit for normals; a subnormal takes exp = 1-bias with hidden bit 0. Go to NORM_A.
  - NORM_A / NORM_B: shift the mantissa left one bit per cycle, decrementing the exponent, until bit MAN_W is 1 (at most MAN_W cycles each).
  - DIV:
    - z_e = a_e - b_e, in an internal signed exponent of EXP_W+2 bits.
    - Restoring division of (MAN_W+1)-bit mantissas, one bit per cycle.
    - Produces MAN_W+4 quotient bits (1 integer bit + MAN_W+3 fraction bits); a remainder != 0 feeds sticky.
    - Exactly MAN_W+4 cycles.
  - NORM:
    - If the quotient integer bit is 0, shift left once and decrement z_e.
    - While z_e < 1-bias, shift right, increment z_e, and OR the lost bits into sticky.
  - ROUND:
    - Round to nearest even: increment when guard && (round || sticky || lsb).
    - On mantissa carry-out, renormalise and increment z_e.
  - PACK:
    - z_e > bias -> signed inf, overflow+inexact.
    - Hidden bit 0 after rounding -> exponent field 0 (subnormal or zero).
    - Otherwise field = z_e + bias.
  - OUT: drive out_valid; return to IDLE on the transfer.
- Latency: input transfer to out_valid is at most 2*MAN_W + MAN_W + 12 cycles for finite operands and exactly 3 cycles for special cases. There is no fixed-latency guarantee.
- Zero and infinity results always carry sign a_s^b_s.
- A new in_valid during busy is ignored (in_ready=0); the source must hold it.

Optional Feature:
- FP_DIV_FLAGS_EN defined:
  - out_flags port exists; flags are computed per operation and held with out_z.
  - inexact = any nonzero guard/round/sticky bit, or overflow.
  - underflow = result tiny (exponent field 0 or zero after rounding) and inexact.
- Not defined: out_flags port and all flag logic are absent; the datapath result is identical.

Test Plan:
- Defaults, in_a=0x4000, in_b=0x3C00 (2.0/1.0) -> out_z=0x4000, flags=0.
- in_a=0x3C00, in_b=0x4200 (1/3) -> out_z=0x3555, inexact=1.
- in_a=0x7BFF, in_b=0x0001 -> out_z=0x7C00, overflow=1, inexact=1. Also: in_a=0x0000, in_b=0x0000 -> 0x7E00, invalid=1. Also: in_a=0xC000, in_b=0x0000 -> 0xFC00, div_zero=1.
- in_a=0x0001, in_b=0x4000 (2^-25, tie) -> out_z=0x0000, underflow=1, inexact=1. Also: in_a=0x0400, in_b=0x4000 -> 0x0200 exact, underflow=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_z stable and in_ready=0 throughout. Then pulse out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst for 1 cycle mid-DIV -> next cycle in_ready=1, out_valid=0. A following 0x4400/0x4000 -> 0x4000. Rerun with EXP_W=8, MAN_W=23: 0x40400000/0x3F800000 -> 0x40400000.
